panel_scan_responder: RTL and testbench

- Panel-side counterpart of the front-panel scanner.
- Decodes the six time-multiplexed group strobes (GREEN1, GREEN2, RED1, RED2, YELLOW1, YELLOW2) and the six PLED lines back into 36 parallel LED bits.
- Answers each strobe on SW1/SW2/SW3 with the matching switch and button bits.
- Used as the simulation panel model and as the driver for a secondary panel on a remote board.
- Also checks scan order and detects a stalled scanner.

---
 rtl/panel_scan_responder.sv | 174 +++++++++++++++++
 tb/tb_panel_scan_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/panel_scan_responder.sv
// Panel-side model of the front-panel scanner: rebuilds 36 LED bits from the
// group strobes, returns switch/button bits, and checks scan order and liveness.
module panel_scan_responder #(
   parameter int TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        GREEN1,
   input  logic        GREEN2,
   input  logic        RED1,
   input  logic        RED2,
   input  logic        YELLOW1,
   input  logic        YELLOW2,
   input  logic        PLED1,
   input  logic        PLED2,
   input  logic        PLED3,
   input  logic        PLED4,
   input  logic        PLED5,
   input  logic        PLED6,
   input  logic [11:0] switches_in,
   input  logic [5:0]  buttons_in,
   input  logic        CLRERR,
   output logic        SW1,
   output logic        SW2,
   output logic        SW3,
   output logic [11:0] green,
   output logic [11:0] red,
   output logic [11:0] yellow,
   output logic        FRAME,
   output logic        SEQERR,
   output logic        STALE
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic {SYNC, RUN} state_t;

   state_t      state, state_nxt;
   logic [2:0]  exp_idx, exp_nxt;
   logic        frame_nxt, seq_set;
   logic [5:0]  stb, pled;
   logic [2:0]  idx;
   logic        none, one_hot, multi, timeout_hit;
   logic [11:0] sw_m, sw_s;
   logic [5:0]  bt_m, bt_s;
   logic [CW-1:0] idle_cnt;

   // Strobe index 0..5 follows scan order G1, G2, R1, R2, Y1, Y2.
   assign stb     = {YELLOW2, YELLOW1, RED2, RED1, GREEN2, GREEN1};
   assign pled    = {PLED6, PLED5, PLED4, PLED3, PLED2, PLED1};
   assign none    = (stb == 6'd0);
   assign one_hot = !none && ((stb & (stb - 6'd1)) == 6'd0);
   assign multi   = !none && !one_hot;
   assign timeout_hit = none && (idle_cnt == TMAX - CW'(1));

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 6; i++)
         if (stb[i]) idx = 3'(i);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sw_m <= '0;
         sw_s <= '0;
         bt_m <= '0;
         bt_s <= '0;
      end else begin
         sw_m <= switches_in;
         sw_s <= sw_m;
         bt_m <= buttons_in;
         bt_s <= bt_m;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         idle_cnt <= '0;
         STALE    <= 1'b1;
      end else if (!none) begin
         idle_cnt <= '0;
         STALE    <= 1'b0;
      end else if (idle_cnt != TMAX) begin
         idle_cnt <= idle_cnt + CW'(1);
         if (timeout_hit) STALE <= 1'b1;
      end
   end

   // A timeout blanks the display so a dead scanner does not leave stale LEDs lit.
   always_ff @(posedge CLK) begin
      if (!RESET_N || timeout_hit) begin
         green  <= '0;
         red    <= '0;
         yellow <= '0;
      end else if (one_hot) begin
         case (idx)
            3'd0:    green[5:0]   <= pled;
            3'd1:    green[11:6]  <= pled;
            3'd2:    red[5:0]     <= pled;
            3'd3:    red[11:6]    <= pled;
            3'd4:    yellow[5:0]  <= pled;
            default: yellow[11:6] <= pled;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state   <= SYNC;
         exp_idx <= 3'd0;
         FRAME   <= 1'b0;
         SEQERR  <= 1'b0;
      end else begin
         state   <= state_nxt;
         exp_idx <= exp_nxt;
         FRAME   <= frame_nxt;
         if (seq_set)     SEQERR <= 1'b1;
         else if (CLRERR) SEQERR <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      exp_nxt   = exp_idx;
      frame_nxt = 1'b0;
      seq_set   = 1'b0;
      if (multi) begin
         seq_set   = 1'b1;
         state_nxt = SYNC;
         exp_nxt   = 3'd0;
      end else if (one_hot) begin
         if (state == SYNC) begin
            if (idx == 3'd0) begin
               state_nxt = RUN;
               exp_nxt   = 3'd1;
            end
         end else if (idx == exp_idx) begin
            if (exp_idx == 3'd5) begin
               frame_nxt = 1'b1;
               exp_nxt   = 3'd0;
            end else begin
               exp_nxt = exp_idx + 3'd1;
            end
         end else begin
            // An out-of-order G1 is itself a valid frame start.
            seq_set   = 1'b1;
            state_nxt = (idx == 3'd0) ? RUN : SYNC;
            exp_nxt   = (idx == 3'd0) ? 3'd1 : 3'd0;
         end
      end else if (timeout_hit) begin
         state_nxt = SYNC;
         exp_nxt   = 3'd0;
      end
   end

   // Return lines are combinational so the scanner samples them in its strobe cycle.
   always_comb begin
      SW1 = 1'b0;
      SW2 = 1'b0;
      SW3 = 1'b0;
      if (one_hot) begin
         case (idx)
            3'd0:    {SW3, SW2, SW1} = {bt_s[5], sw_s[11], sw_s[5]};
            3'd1:    {SW3, SW2, SW1} = {bt_s[4], sw_s[10], sw_s[4]};
            3'd2:    {SW3, SW2, SW1} = {bt_s[3], sw_s[9],  sw_s[3]};
            3'd3:    {SW3, SW2, SW1} = {bt_s[2], sw_s[8],  sw_s[2]};
            3'd4:    {SW3, SW2, SW1} = {bt_s[1], sw_s[7],  sw_s[1]};
            default: {SW3, SW2, SW1} = {bt_s[0], sw_s[6],  sw_s[0]};
         endcase
      end
   end

endmodule

// File: tb/tb_panel_scan_responder.sv
// Directed bench for panel_scan_responder: scans, switch return, order errors,
// collisions, idle timeout and mid-frame reset.
module tb_panel_scan_responder;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [5:0]  stb = 6'd0;
   logic [5:0]  pled = 6'd0;
   logic [11:0] switches_in = 12'd0;
   logic [5:0]  buttons_in = 6'd0;
   logic        CLRERR = 1'b0;
   logic        SW1, SW2, SW3;
   logic [11:0] green, red, yellow;
   logic        FRAME, SEQERR, STALE;

   int n_checks = 0;
   int n_err = 0;
   logic [2:0] exp_q[$];

   panel_scan_responder #(.TIMEOUT(64)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .GREEN1(stb[0]), .GREEN2(stb[1]), .RED1(stb[2]),
      .RED2(stb[3]), .YELLOW1(stb[4]), .YELLOW2(stb[5]),
      .PLED1(pled[0]), .PLED2(pled[1]), .PLED3(pled[2]),
      .PLED4(pled[3]), .PLED5(pled[4]), .PLED6(pled[5]),
      .switches_in(switches_in), .buttons_in(buttons_in), .CLRERR(CLRERR),
      .SW1(SW1), .SW2(SW2), .SW3(SW3),
      .green(green), .red(red), .yellow(yellow),
      .FRAME(FRAME), .SEQERR(SEQERR), .STALE(STALE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
   task automatic drive(input logic [5:0] s, input logic [5:0] p);
      stb  = s;
      pled = p;
      @(posedge CLK);
      #1;
   endtask

   task automatic scan(input logic [11:0] g, input logic [11:0] r,
                       input logic [11:0] y, input logic exp_frame);
      logic [5:0] d[6];
      d[0] = g[5:0]; d[1] = g[11:6];
      d[2] = r[5:0]; d[3] = r[11:6];
      d[4] = y[5:0]; d[5] = y[11:6];
      for (int k = 0; k < 6; k++) begin
         drive(6'(1 << k), d[k]);
         if (k == 0) chk("stale_after_g1", 36'(STALE), 36'd0);
         if (k < 5) chk("frame_mid", 36'(FRAME), 36'd0);
         else       chk("frame_end", 36'(FRAME), 36'(exp_frame));
      end
      chk("scan_green", 36'(green), 36'(g));
      chk("scan_red", 36'(red), 36'(r));
      chk("scan_yellow", 36'(yellow), 36'(y));
      drive(6'd0, 6'd0);
      chk("frame_gap", 36'(FRAME), 36'd0);
      drive(6'd0, 6'd0);
   endtask

   initial begin
      logic [11:0] sw_c, sw_got;
      logic [5:0]  bt_c, bt_got;

      // Reset state
      RESET_N = 1'b0;
      drive(6'd0, 6'd0);
      drive(6'd0, 6'd0);
      RESET_N = 1'b1;
      chk("rst_green", 36'(green), 36'd0);
      chk("rst_red", 36'(red), 36'd0);
      chk("rst_yellow", 36'(yellow), 36'd0);
      chk("rst_frame", 36'(FRAME), 36'd0);
      chk("rst_seqerr", 36'(SEQERR), 36'd0);
      chk("rst_stale", 36'(STALE), 36'd1);

      // Nominal scans, one FRAME per 8 cycles
      scan(12'hA5C, 12'h3F0, 12'h81F, 1'b1);
      scan(12'hA5C, 12'h3F0, 12'h81F, 1'b1);
      chk("nom_seqerr", 36'(SEQERR), 36'd0);

      // Switch / button return path
      sw_c = 12'hC35;
      bt_c = 6'h2A;
      switches_in = sw_c;
      buttons_in  = bt_c;
      drive(6'd0, 6'd0);
      drive(6'd0, 6'd0);
      drive(6'd0, 6'd0);
      sw_got = '0;
      bt_got = '0;
      for (int k = 0; k < 6; k++) begin
         stb  = 6'(1 << k);
         pled = 6'd0;
         #1;
         exp_q.push_back({bt_c[5-k], sw_c[11-k], sw_c[5-k]});
         sw_got[5-k]  = SW1;
         sw_got[11-k] = SW2;
         bt_got[5-k]  = SW3;
         chk("sw_triple", 36'({SW3, SW2, SW1}), 36'(exp_q.pop_front()));
         @(posedge CLK);
         #1;
      end
      stb = 6'd0;
      #1;
      chk("sw_idle_zero", 36'({SW3, SW2, SW1}), 36'd0);
      chk("sw_reassembled", 36'(sw_got), 36'hC35);
      chk("bt_reassembled", 36'(bt_got), 36'h2A);
      drive(6'd0, 6'd0);

      // Order error: G1, G2, R2
      drive(6'b000001, 6'd0);
      drive(6'b000010, 6'd0);
      drive(6'b001000, 6'h2D);
      chk("ord_seqerr", 36'(SEQERR), 36'd1);
      chk("ord_red", 36'(red), 36'hB40);
      chk("ord_frame", 36'(FRAME), 36'd0);
      drive(6'd0, 6'd0);
      scan(12'hA5C, 12'h3F0, 12'h81F, 1'b1);
      chk("ord_seqerr_sticky", 36'(SEQERR), 36'd1);
      CLRERR = 1'b1;
      drive(6'd0, 6'd0);
      CLRERR = 1'b0;
      chk("ord_clrerr", 36'(SEQERR), 36'd0);

      // Collision mid-frame; set beats a simultaneous CLRERR
      drive(6'b000001, 6'h1C);
      drive(6'b000010, 6'h29);
      stb    = 6'b000110;
      pled   = 6'h3F;
      CLRERR = 1'b1;
      #1;
      chk("col_sw_zero", 36'({SW3, SW2, SW1}), 36'd0);
      @(posedge CLK);
      #1;
      CLRERR = 1'b0;
      chk("col_green", 36'(green), 36'hA5C);
      chk("col_red", 36'(red), 36'h3F0);
      chk("col_seqerr", 36'(SEQERR), 36'd1);
      CLRERR = 1'b1;
      drive(6'd0, 6'd0);
      CLRERR = 1'b0;
      chk("col_clr", 36'(SEQERR), 36'd0);
      // In SYNC a lone R2 is captured without error
      drive(6'b001000, 6'h15);
      chk("col_sync_red", 36'(red), 36'h570);
      chk("col_sync_noerr", 36'(SEQERR), 36'd0);
      drive(6'd0, 6'd0);
      scan(12'hA5C, 12'h3F0, 12'h81F, 1'b1);

      // Stall: scan already gave 2 idle cycles; 61 more makes 63
      for (int i = 0; i < 61; i++) drive(6'd0, 6'd0);
      chk("stall63_stale", 36'(STALE), 36'd0);
      chk("stall63_green", 36'(green), 36'hA5C);
      drive(6'd0, 6'd0);
      chk("stall64_stale", 36'(STALE), 36'd1);
      chk("stall64_leds", 36'({green, red, yellow}), 36'd0);
      chk("stall64_seqerr", 36'(SEQERR), 36'd0);
      drive(6'b000001, 6'h1C);
      chk("stall_g1_stale", 36'(STALE), 36'd0);
      chk("stall_g1_green", 36'(green), 36'h01C);

      // Reset after R1 of a partial frame
      drive(6'b000010, 6'h29);
      drive(6'b000100, 6'h30);
      RESET_N = 1'b0;
      drive(6'd0, 6'd0);
      RESET_N = 1'b1;
      chk("mrst_leds", 36'({green, red, yellow}), 36'd0);
      chk("mrst_frame", 36'(FRAME), 36'd0);
      chk("mrst_seqerr", 36'(SEQERR), 36'd0);
      chk("mrst_stale", 36'(STALE), 36'd1);
      drive(6'b001000, 6'h0F);
      drive(6'b010000, 6'h1F);
      drive(6'b100000, 6'h20);
      chk("mrst_no_frame", 36'(FRAME), 36'd0);
      chk("mrst_no_err", 36'(SEQERR), 36'd0);
      chk("mrst_yellow", 36'(yellow), 36'h81F);
      drive(6'd0, 6'd0);
      drive(6'd0, 6'd0);
      scan(12'h123, 12'h456, 12'h789, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
